// File: rtl/spi_pkg.sv
// Shared SPI definitions used by both the SPI master and the SPI slave.
package spi_pkg;

    // {CPOL, CPHA} encodings
    typedef enum logic [1:0] {
        MODE0 = 2'd0,
        MODE1 = 2'd1,
        MODE2 = 2'd2,
        MODE3 = 2'd3
    } spi_mode_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } spi_state_e;

    // Bit counter width; words are at most 16 bits long.
    localparam int BITCNT_W      = 5;
    localparam int MAX_WORD_LEN  = 16;

    // Word returned when the host has nothing queued.
    localparam int DUMMY_DEFAULT = 'hFF;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser with rise/fall pulses, detected against one extra flop.
module spi_sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync;
    logic              prev;

    // Synchroniser chain plus the history flop used for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= {STAGES{RESET_VAL}};
            prev <= RESET_VAL;
        end else begin
            sync <= {sync[STAGES-2:0], din};
            prev <= sync[STAGES-1];
        end
    end

    assign level = sync[STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;

endmodule

// File: rtl/spi_slave.sv
// SPI slave: oversampled pins, all four modes, MSB/LSB first, tx holding buffer and rx register.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | ss high; miso held at 1, waiting for ss to fall
// ST_ACTIVE | ss low; sampling mosi and shifting miso on sck edges
module spi_slave
    import spi_pkg::*;
#(
    parameter int                  WORD_LEN    = 8,
    parameter int                  SYNC_STAGES = 2,
    parameter logic [WORD_LEN-1:0] DUMMY       = WORD_LEN'(DUMMY_DEFAULT)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sck,
    input  logic                ss,
    input  logic                mosi,
    output logic                miso,
    output logic                miso_oe,
    input  logic [1:0]          mode,
    input  logic                lsbfirst,
    input  logic [WORD_LEN-1:0] tx_data,
    input  logic                tx_wr,
    output logic                tx_empty,
    output logic                tx_err,
    output logic [WORD_LEN-1:0] rx_data,
    output logic                rx_valid,
    input  logic                rx_rd,
    output logic                rx_ovr,
    input  logic                clr_err,
    output logic                busy
);

    localparam logic [BITCNT_W-1:0] LAST_CNT = BITCNT_W'(WORD_LEN);

    logic sck_s, sck_rise, sck_fall;
    logic ss_s, ss_rise, ss_fall;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused;
    logic ss_level_unused, sck_level_unused;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
        .clk(clk), .rst(rst), .din(sck),
        .level(sck_s), .rise(sck_rise), .fall(sck_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
        .clk(clk), .rst(rst), .din(ss),
        .level(ss_s), .rise(ss_rise), .fall(ss_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_mosi (
        .clk(clk), .rst(rst), .din(mosi),
        .level(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    // Only edges of sck/ss matter; their levels are not needed.
    assign ss_level_unused  = ss_s;
    assign sck_level_unused = sck_s;

    spi_state_e          state, state_n;
    logic                cpol_q, cpol_n;
    logic                cpha_q, cpha_n;
    logic                lsb_q, lsb_n;
    logic [BITCNT_W-1:0] bitcnt, bitcnt_n;
    logic [WORD_LEN-1:0] shift_in, shift_in_n;
    logic [WORD_LEN-1:0] shift_out, shift_out_n;
    logic [WORD_LEN-1:0] tx_buf, tx_buf_n;
    logic [WORD_LEN-1:0] rx_data_q, rx_data_n;
    logic                miso_q, miso_n;
    logic                tx_empty_q, tx_empty_n;
    logic                tx_err_q, tx_err_n;
    logic                rx_valid_q, rx_valid_n;
    logic                rx_ovr_q, rx_ovr_n;

    function automatic logic first_bit(input logic [WORD_LEN-1:0] w, input logic lsb);
        return lsb ? w[0] : w[WORD_LEN-1];
    endfunction

    // Shift the word one place in transmission order, inserting b at the vacated end.
    function automatic logic [WORD_LEN-1:0] shift_word(input logic [WORD_LEN-1:0] w,
                                                      input logic lsb, input logic b);
        return lsb ? {b, w[WORD_LEN-1:1]} : {w[WORD_LEN-2:0], b};
    endfunction

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            lsb_q      <= 1'b0;
            bitcnt     <= '0;
            shift_in   <= '0;
            shift_out  <= '0;
            tx_buf     <= '0;
            rx_data_q  <= '0;
            miso_q     <= 1'b1;
            tx_empty_q <= 1'b1;
            tx_err_q   <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_ovr_q   <= 1'b0;
        end else begin
            state      <= state_n;
            cpol_q     <= cpol_n;
            cpha_q     <= cpha_n;
            lsb_q      <= lsb_n;
            bitcnt     <= bitcnt_n;
            shift_in   <= shift_in_n;
            shift_out  <= shift_out_n;
            tx_buf     <= tx_buf_n;
            rx_data_q  <= rx_data_n;
            miso_q     <= miso_n;
            tx_empty_q <= tx_empty_n;
            tx_err_q   <= tx_err_n;
            rx_valid_q <= rx_valid_n;
            rx_ovr_q   <= rx_ovr_n;
        end
    end

    logic                lead, trail, sample_edge, shift_edge;
    logic                load, load_cpha, load_lsb, word_done;
    logic                tx_err_set, rx_ovr_set;
    logic [WORD_LEN-1:0] load_word;
    logic [BITCNT_W-1:0] bitcnt_inc;

    // Next-state, shift engine, tx buffer and rx register updates.
    always_comb begin
        state_n     = state;
        cpol_n      = cpol_q;
        cpha_n      = cpha_q;
        lsb_n       = lsb_q;
        bitcnt_n    = bitcnt;
        shift_in_n  = shift_in;
        shift_out_n = shift_out;
        tx_buf_n    = tx_buf;
        rx_data_n   = rx_data_q;
        miso_n      = miso_q;
        tx_empty_n  = tx_empty_q;
        rx_valid_n  = rx_valid_q;
        load        = 1'b0;
        load_cpha   = cpha_q;
        load_lsb    = lsb_q;
        load_word   = DUMMY;
        word_done   = 1'b0;
        tx_err_set  = 1'b0;
        rx_ovr_set  = 1'b0;
        bitcnt_inc  = bitcnt + 1'b1;

        lead        = cpol_q ? sck_fall : sck_rise;
        trail       = cpol_q ? sck_rise : sck_fall;
        sample_edge = cpha_q ? trail : lead;
        shift_edge  = cpha_q ? lead  : trail;

        case (state)
            ST_IDLE: begin
                miso_n = 1'b1;
                if (ss_fall) begin
                    state_n    = ST_ACTIVE;
                    cpol_n     = mode[1];
                    cpha_n     = mode[0];
                    lsb_n      = lsbfirst;
                    bitcnt_n   = '0;
                    shift_in_n = '0;
                    load       = 1'b1;
                    load_cpha  = mode[0];
                    load_lsb   = lsbfirst;
                end
            end
            ST_ACTIVE: begin
                if (ss_rise) begin
                    state_n  = ST_IDLE;
                    miso_n   = 1'b1;
                    bitcnt_n = '0;
                end else begin
                    if (sample_edge) begin
                        shift_in_n = shift_word(shift_in, lsb_q, mosi_s);
                        if (bitcnt_inc == LAST_CNT) begin
                            word_done = 1'b1;
                            bitcnt_n  = '0;
                            load      = 1'b1;
                        end else begin
                            bitcnt_n = bitcnt_inc;
                        end
                    end
                    // With CPHA=0 the trailing edge that closes a word must not shift:
                    // the next word's first bit was already driven at word done.
                    if (shift_edge && (cpha_q || bitcnt != '0)) begin
                        miso_n      = first_bit(shift_out, lsb_q);
                        shift_out_n = shift_word(shift_out, lsb_q, 1'b1);
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase

        if (load) begin
            if (!tx_empty_q) begin
                load_word  = tx_buf;
                tx_empty_n = 1'b1;
            end
            if (!load_cpha) begin
                miso_n      = first_bit(load_word, load_lsb);
                shift_out_n = shift_word(load_word, load_lsb, 1'b1);
            end else begin
                shift_out_n = load_word;
            end
        end

        // A load frees the buffer in the same cycle, so a coincident write is accepted.
        if (tx_wr) begin
            if (tx_empty_q || load) begin
                tx_buf_n   = tx_data;
                tx_empty_n = 1'b0;
            end else begin
                tx_err_set = 1'b1;
            end
        end

        if (word_done) begin
            rx_data_n  = shift_in_n;
            rx_valid_n = 1'b1;
            rx_ovr_set = rx_valid_q & ~rx_rd;
        end else if (rx_rd) begin
            rx_valid_n = 1'b0;
        end

        tx_err_n = (tx_err_q & ~clr_err) | tx_err_set;
        rx_ovr_n = (rx_ovr_q & ~clr_err) | rx_ovr_set;
    end

    assign miso     = miso_q;
    assign miso_oe  = (state == ST_ACTIVE);
    assign busy     = (state == ST_ACTIVE);
    assign tx_empty = tx_empty_q;
    assign tx_err   = tx_err_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign rx_ovr   = rx_ovr_q;

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: table of single-word transfers plus corner-case sequences.
module tb_spi_slave;

    localparam int HALF = 6;  // sck half period in clk cycles

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sck = 1'b0;
    logic       ss = 1'b1;
    logic       mosi = 1'b1;
    logic       miso, miso_oe;
    logic [1:0] mode = 2'd0;
    logic       lsbfirst = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_wr = 1'b0;
    logic       tx_empty, tx_err;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_rd = 1'b0;
    logic       rx_ovr;
    logic       clr_err = 1'b0;
    logic       busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_rx_q[$];
    logic [7:0] exp_miso_q[$];

    spi_slave #(.WORD_LEN(8), .SYNC_STAGES(2), .DUMMY(8'hFF)) dut (
        .clk(clk), .rst(rst), .sck(sck), .ss(ss), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .mode(mode), .lsbfirst(lsbfirst),
        .tx_data(tx_data), .tx_wr(tx_wr), .tx_empty(tx_empty), .tx_err(tx_err),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_rd(rx_rd), .rx_ovr(rx_ovr),
        .clr_err(clr_err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] md;
        logic       lsb;
        logic       wr;
        logic [7:0] tx;
        logic [7:0] mtx;
        logic [7:0] exp_miso;
        logic [7:0] exp_rx;
    } vec_t;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_tx(input logic [7:0] d);
        @(negedge clk);
        tx_data = d;
        tx_wr   = 1'b1;
        @(negedge clk);
        tx_wr   = 1'b0;
    endtask

    task automatic pulse_rd();
        @(negedge clk);
        rx_rd = 1'b1;
        @(negedge clk);
        rx_rd = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
    endtask

    task automatic ss_start(input logic [1:0] md, input logic lsb);
        mode     = md;
        lsbfirst = lsb;
        sck      = md[1];
        mosi     = 1'b1;
        wait_clk(8);
        ss = 1'b0;
        wait_clk(4);
    endtask

    task automatic ss_end();
        wait_clk(4);
        ss = 1'b1;
        wait_clk(8);
    endtask

    // Master side of one word (or a partial word of nbits); returns what it read from miso.
    task automatic xfer(input logic [1:0] md, input logic lsb, input logic [7:0] mtx,
                        input int nbits, output logic [7:0] rd);
        logic cpol, cpha;
        int   idx;
        cpol = md[1];
        cpha = md[0];
        rd   = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            idx = lsb ? i : 7 - i;
            if (!cpha) begin
                mosi = mtx[idx];
                wait_clk(HALF);
                sck = ~cpol;
                rd[idx] = miso;
                wait_clk(HALF);
                sck = cpol;
            end else begin
                sck  = ~cpol;
                mosi = mtx[idx];
                wait_clk(HALF);
                sck = cpol;
                rd[idx] = miso;
                wait_clk(HALF);
            end
        end
        wait_clk(HALF);
    endtask

    vec_t       vecs[9];
    logic [7:0] rd, rd2;
    logic [7:0] exp_v;

    initial begin
        vecs[0] = '{2'd0, 1'b0, 1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h3C};
        vecs[1] = '{2'd1, 1'b1, 1'b1, 8'h81, 8'h42, 8'h81, 8'h42};
        vecs[2] = '{2'd2, 1'b1, 1'b1, 8'h81, 8'h42, 8'h81, 8'h42};
        vecs[3] = '{2'd3, 1'b1, 1'b1, 8'h81, 8'h42, 8'h81, 8'h42};
        vecs[4] = '{2'd0, 1'b0, 1'b0, 8'h00, 8'h55, 8'hFF, 8'h55};
        vecs[5] = '{2'd0, 1'b1, 1'b1, 8'h1E, 8'hB4, 8'h1E, 8'hB4};
        vecs[6] = '{2'd1, 1'b0, 1'b1, 8'h6C, 8'h93, 8'h6C, 8'h93};
        vecs[7] = '{2'd2, 1'b1, 1'b1, 8'h35, 8'hCA, 8'h35, 8'hCA};
        vecs[8] = '{2'd3, 1'b0, 1'b1, 8'hF0, 8'h0D, 8'hF0, 8'h0D};

        // Reset values
        wait_clk(3);
        check("rst miso", miso, 1);
        check("rst miso_oe", miso_oe, 0);
        check("rst tx_empty", tx_empty, 1);
        check("rst flags", {tx_err, rx_valid, rx_ovr, busy}, 0);
        check("rst rx_data", rx_data, 0);
        rst = 1'b0;
        wait_clk(4);

        // Table of single-word transfers
        foreach (vecs[k]) begin
            if (vecs[k].wr) write_tx(vecs[k].tx);
            exp_miso_q.push_back(vecs[k].exp_miso);
            exp_rx_q.push_back(vecs[k].exp_rx);
            ss_start(vecs[k].md, vecs[k].lsb);
            check($sformatf("v%0d busy", k), {busy, miso_oe}, 2'b11);
            check($sformatf("v%0d tx_empty at start", k), tx_empty, 1);
            xfer(vecs[k].md, vecs[k].lsb, vecs[k].mtx, 8, rd);
            ss_end();
            exp_v = exp_miso_q.pop_front();
            check($sformatf("v%0d miso word", k), rd, exp_v);
            exp_v = exp_rx_q.pop_front();
            check($sformatf("v%0d rx_data", k), rx_data, exp_v);
            check($sformatf("v%0d rx_valid", k), rx_valid, 1);
            check($sformatf("v%0d idle miso", k), {miso, miso_oe, busy}, 3'b100);
            pulse_rd();
            check($sformatf("v%0d rx_valid after rd", k), rx_valid, 0);
        end

        // Back-to-back words under one ss low, no read in between -> overrun
        write_tx(8'h3C);
        exp_miso_q.push_back(8'h3C);
        exp_miso_q.push_back(8'hC6);
        exp_rx_q.push_back(8'h22);
        ss_start(2'd0, 1'b0);
        check("b2b tx_empty after load", tx_empty, 1);
        write_tx(8'hC6);
        xfer(2'd0, 1'b0, 8'h11, 8, rd);
        xfer(2'd0, 1'b0, 8'h22, 8, rd2);
        ss_end();
        exp_v = exp_miso_q.pop_front();
        check("b2b miso word1", rd, exp_v);
        exp_v = exp_miso_q.pop_front();
        check("b2b miso word2", rd2, exp_v);
        exp_v = exp_rx_q.pop_front();
        check("b2b rx_data", rx_data, exp_v);
        check("b2b rx_ovr", rx_ovr, 1);
        pulse_clr();
        check("b2b rx_ovr cleared", rx_ovr, 0);
        pulse_rd();

        // Abort after 5 bits, then a full aligned word
        ss_start(2'd0, 1'b0);
        xfer(2'd0, 1'b0, 8'hF0, 5, rd);
        ss_end();
        check("abort rx_valid", rx_valid, 0);
        check("abort busy", busy, 0);
        exp_rx_q.push_back(8'h99);
        exp_miso_q.push_back(8'hFF);
        ss_start(2'd0, 1'b0);
        xfer(2'd0, 1'b0, 8'h99, 8, rd);
        ss_end();
        exp_v = exp_rx_q.pop_front();
        check("post-abort rx_data", rx_data, exp_v);
        exp_v = exp_miso_q.pop_front();
        check("post-abort miso", rd, exp_v);
        check("post-abort rx_valid", rx_valid, 1);
        pulse_rd();

        // Write while buffer full -> error, first word kept
        write_tx(8'h12);
        write_tx(8'h34);
        check("txerr tx_err", tx_err, 1);
        check("txerr tx_empty", tx_empty, 0);
        exp_miso_q.push_back(8'h12);
        ss_start(2'd1, 1'b0);
        xfer(2'd1, 1'b0, 8'h00, 8, rd);
        ss_end();
        exp_v = exp_miso_q.pop_front();
        check("txerr miso", rd, exp_v);
        pulse_clr();
        check("txerr cleared", tx_err, 0);

        // Reset mid-word
        write_tx(8'h77);
        ss_start(2'd0, 1'b0);
        xfer(2'd0, 1'b0, 8'hAA, 3, rd);
        @(negedge clk);
        rst = 1'b1;
        wait_clk(2);
        check("midrst miso", miso, 1);
        check("midrst miso_oe", miso_oe, 0);
        check("midrst tx_empty", tx_empty, 1);
        check("midrst flags", {tx_err, rx_valid, rx_ovr, busy}, 0);
        check("midrst rx_data", rx_data, 0);
        ss  = 1'b1;
        sck = 1'b0;
        wait_clk(2);
        rst = 1'b0;
        wait_clk(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
